// File: rtl/wide_sub_seq.sv
// wide_sub_seq -- multi-cycle wide unsigned subtractor.
//
// Computes diff = sum - b (mod 2**WIDTH) one CHUNK-bit slice per clock.
// The borrow between slices is carried in a flop. This is the inverse of the
// wide adder datapath and recovers an operand from a wide sum. Valid/ready
// handshakes are used on both the operand side and the result side.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   CHUNK  slice width per cycle (1..WIDTH); NCHUNK = ceil(WIDTH/CHUNK)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (high only in IDLE)
//   sum        minuend
//   b          subtrahend
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   diff       sum - b mod 2**WIDTH (slices change while running;
//              only meaningful with out_valid=1)
//   borrow     1 when b > sum (unsigned)
//
// Optional feature
//   WIDE_SUB_SAT_EN  when defined, a final borrow forces diff to zero
//                    (saturating unsigned subtract); borrow still reads 1.
//
// Latency: out_valid rises NCHUNK cycles after the input handshake edge.

module wide_sub_seq #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int EXTW   = NCHUNK * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [WIDTH-1:0]  sum_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [WIDTH-1:0]  diff_n;
    logic [EXTW-1:0]   sum_ext;
    logic [EXTW-1:0]   b_ext;
    logic [CHUNK-1:0]  s_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK-1:0]  d_sl;
    logic [IDXW-1:0]   idx;
    logic              bflop;
    logic              bo;
    logic              accept;
    logic              last;

`ifdef WIDE_SUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] d,
                                                  input logic             bout);
        return bout ? '0 : d;
    endfunction
`endif

    assign accept    = (state == IDLE) && in_valid;
    assign last      = (idx == LAST_IDX);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign borrow    = bflop;

    // Operands are zero-padded up to a whole number of slices. Borrow through
    // the zero pad bits reproduces the borrow out of bit WIDTH-1 unchanged,
    // so the slice borrow-out of the last slice is the true final borrow.
    always_comb begin
        sum_ext              = '0;
        b_ext                = '0;
        sum_ext[WIDTH-1:0]   = sum_q;
        b_ext[WIDTH-1:0]     = b_q;
        s_sl                 = sum_ext[int'(idx)*CHUNK +: CHUNK];
        b_sl                 = b_ext[int'(idx)*CHUNK +: CHUNK];
        {bo, d_sl}           = {1'b0, s_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, bflop};
    end

    // Merge the current slice into the result; pad bits are simply dropped.
    always_comb begin
        diff_n = diff_q;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i / CHUNK) == int'(idx)) begin
                diff_n[i] = d_sl[i % CHUNK];
            end
        end
`ifdef WIDE_SUB_SAT_EN
        if (last) begin
            diff_n = sat_diff(diff_n, bo);
        end
`endif
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            bflop  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            bflop  <= 1'b0;
            idx    <= '0;
        end else if (state == RUN) begin
            diff_q <= diff_n;
            bflop  <= bo;
            idx    <= last ? '0 : idx + IDXW'(1);
        end
    end

    // Operand capture: pure data, only loaded on the input handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            sum_q <= sum;
            b_q   <= b;
        end
    end

endmodule
